// File: rtl/mem_loader.sv
// Purpose: streams an image into a local RAM from address 0 and exposes a synchronous read port.
// Latency: a beat is written on the edge it is accepted; rd_data is valid one edge after rd_en.
// Backpressure: in_ready is high only in LOAD, so beats offered in IDLE or DONE wait for the next load.
module mem_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [ADDRESS_WIDTH:0]   word_count,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     wr_en;
  logic                     at_last_addr;

  // in_ready is a registered copy of "state == LOAD", so this is the accept strobe.
  assign wr_en        = in_valid && in_ready;
  assign at_last_addr = (wr_ptr == LAST_ADDR);

  // Load sequencer: all handshake/status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      wr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            wr_ptr     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            word_count <= word_count + 1'b1;
            // The pointer parks on the top address instead of wrapping back over address 0.
            if (!at_last_addr) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (in_last || at_last_addr) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              // Memory full without the end marker: image was truncated.
              if (!in_last) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  // Stream-side write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Synchronous read port; sampling mem with a non-blocking read gives old data on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_address];
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Purpose: directed bench for mem_loader with an 8-deep memory, checked against a per-cycle reference model.
// Latency: inputs change 1 time unit after a rising edge; outputs are compared on the falling edge.
// Backpressure: beats offered while in_ready is low must be dropped; the model enforces that.
module tb_mem_loader;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   word_count;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic [DW-1:0] rd_data;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count),
    .rd_en      (rd_en),
    .rd_address (rd_address),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = loading, 2 = completion cycle.
  int            m_phase    = 0;
  int            m_cnt      = 0;
  bit            m_ovf      = 1'b0;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  logic [DW-1:0] m_rd       = '0;
  bit            m_rd_known = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: reads happen before writes so a same-cycle collision sees old data.
  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase    = 0;
        m_cnt      = 0;
        m_ovf      = 1'b0;
        m_rd       = '0;
        m_rd_known = 1'b1;
      end else begin
        if (rd_en) begin
          m_rd       = m_mem[rd_address];
          m_rd_known = m_known[rd_address];
        end
        if (m_phase == 0) begin
          if (start) begin
            m_phase = 1;
            m_cnt   = 0;
            m_ovf   = 1'b0;
          end
        end else if (m_phase == 1) begin
          if (in_valid) begin
            m_mem[m_cnt]   = in_data;
            m_known[m_cnt] = 1'b1;
            m_cnt++;
            if (in_last) m_phase = 2;
            else if (m_cnt == DEPTH) begin
              m_phase = 2;
              m_ovf   = 1'b1;
            end
          end
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 1});
      chk("busy", {31'd0, busy}, {31'd0, m_phase == 1});
      chk("done", {31'd0, done}, {31'd0, m_phase == 2});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("word_count", 32'(word_count), 32'(m_cnt));
      if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en      = 1'b1;
    rd_address = a;
    tick();
    rd_en = 1'b0;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic 4-beat image
    do_start();
    chk("load_in_ready", {31'd0, in_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    chk("img4_done", {31'd0, done}, 32'd1);
    chk("img4_count", 32'(word_count), 32'd4);
    chk("img4_ovf", {31'd0, overflow}, 32'd0);
    tick();
    chk("img4_done_pulse", {31'd0, done}, 32'd0);
    chk("img4_count_hold", 32'(word_count), 32'd4);
    rd("img4_rd0", 3'd0, 8'h11);
    rd("img4_rd1", 3'd1, 8'h22);
    rd("img4_rd2", 3'd2, 8'h33);
    rd("img4_rd3", 3'd3, 8'h44);

    // Gapped valid: idle cycles must not write
    do_start();
    beat(8'h51, 1'b0);
    tick();
    beat(8'h52, 1'b0);
    tick();
    beat(8'h53, 1'b1);
    chk("gap_count", 32'(word_count), 32'd3);
    tick();
    rd("gap_rd0", 3'd0, 8'h51);
    rd("gap_rd1", 3'd1, 8'h52);
    rd("gap_rd2", 3'd2, 8'h53);
    rd("gap_rd3_old", 3'd3, 8'h44);

    // Fill without in_last: overflow, 9th beat refused
    do_start();
    for (int i = 0; i < DEPTH; i++) beat(8'(8'h60 + i), 1'b0);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_count", 32'(word_count), 32'd8);
    chk("ovf_done", {31'd0, done}, 32'd1);
    chk("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    beat(8'h99, 1'b0);
    chk("ovf_count_hold", 32'(word_count), 32'd8);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    rd("ovf_no_wrap", 3'd0, 8'h60);
    rd("ovf_top", 3'd7, 8'h67);

    // Exact fill with in_last on the final slot
    do_start();
    chk("exact_ovf_cleared", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < DEPTH; i++) beat(8'(8'h70 + i), i == DEPTH - 1);
    chk("exact_ovf", {31'd0, overflow}, 32'd0);
    chk("exact_count", 32'(word_count), 32'd8);
    tick();
    rd("exact_rd7", 3'd7, 8'h77);

    // Reset mid-load
    do_start();
    beat(8'hA1, 1'b0);
    beat(8'hA2, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA3;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("arst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    rd("arst_rd0", 3'd0, 8'hA1);
    rd("arst_rd1", 3'd1, 8'hA2);
    rd("arst_rd2_old", 3'd2, 8'h72);
    do_start();
    beat(8'hC1, 1'b1);
    tick();
    chk("restart_count", 32'(word_count), 32'd1);
    rd("restart_rd0", 3'd0, 8'hC1);

    // Read-first collision on address 0
    do_start();
    beat(8'hAA, 1'b1);
    tick();
    do_start();
    in_valid   = 1'b1;
    in_data    = 8'hBB;
    in_last    = 1'b1;
    rd_en      = 1'b1;
    rd_address = 3'd0;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rw_old", 32'(rd_data), 32'h0AA);
    tick();
    chk("rw_new", 32'(rd_data), 32'h0BB);
    rd_en      = 1'b0;
    rd_address = 3'd5;
    tick();
    chk("rd_hold", 32'(rd_data), 32'h0BB);
    // start must be ignored while loading
    do_start();
    start = 1'b1;
    beat(8'hD0, 1'b0);
    start = 1'b0;
    beat(8'hD1, 1'b1);
    chk("start_ignored_count", 32'(word_count), 32'd2);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the word width in bits.
REQ-002 The module SHALL have parameter ADDRESS_WIDTH, default 10, meaning the address width; memory depth DEPTH = 2^ADDRESS_WIDTH.
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load at address 0.
REQ-007 in_valid  input  1  write-stream beat valid.
REQ-008 in_ready  output  1  loader can accept a beat.
REQ-009 in_data  input  DATA_WIDTH  write-stream word.
REQ-010 in_last  input  1  marks the final beat of the image.
REQ-011 busy  output  1  high while in LOAD.
REQ-012 done  output  1  single-cycle pulse when a load completes.
REQ-013 overflow  output  1  sticky flag: memory filled before in_last was seen.
REQ-014 word_count  output  ADDRESS_WIDTH+1  number of words written in the current or last load.
REQ-015 rd_en  input  1  read enable.
REQ-016 rd_address  input  ADDRESS_WIDTH  read address.
REQ-017 rd_data  output  DATA_WIDTH  registered read data.

Function
REQ-018 Internal storage SHALL be DEPTH words of DATA_WIDTH bits with one write port (stream side) and one synchronous read port.
REQ-019 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-020 IDLE: in_ready=0; start=1 -> LOAD next cycle; write pointer, word_count and overflow cleared to 0 on that edge.
REQ-021 LOAD: in_ready=1, busy=1; a beat is accepted only when in_valid && in_ready.
REQ-022 On an accepted beat, in_data SHALL be written to mem[write pointer]; the write pointer and word_count SHALL each increment by 1.
REQ-023 An accepted beat with in_last=1 SHALL transition LOAD -> DONE.
REQ-024 When the beat written to address DEPTH-1 has in_last=0, overflow SHALL set to 1 and the FSM SHALL go LOAD -> DONE; the write pointer SHALL NOT wrap to 0.
REQ-025 When the beat to address DEPTH-1 has in_last=1, overflow SHALL stay 0; word_count SHALL equal DEPTH.
REQ-026 DONE: done=1 for exactly that one cycle, in_ready=0, busy=0; unconditionally -> IDLE.
REQ-027 start SHALL be ignored in LOAD and DONE.
REQ-028 word_count and overflow SHALL hold their values in IDLE until the next start.
REQ-029 Read: when rd_en=1, rd_data SHALL equal mem[rd_address] on the following edge (1-cycle latency); rd_data SHALL hold when rd_en=0.
REQ-030 A read and a write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-031 Reads SHALL be allowed in every state.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, in_ready=0, busy=0, done=0, overflow=0, word_count=0, write pointer=0, rd_data=0.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 Reset during LOAD SHALL abort the load; words already written remain in memory; no done pulse SHALL be issued.

Verification
REQ-035 start, 4 beats 0x11,0x22,0x33,0x44 with in_last on 4th -> done one cycle later, word_count=4, overflow=0; reads of addr 0..3 return 0x11..0x44 one cycle after rd_en.
REQ-036 in_valid toggled 1/0 each cycle over 3 beats -> only valid cycles write; word_count=3; addresses contiguous 0..2.
REQ-037 ADDRESS_WIDTH=3, 8 beats with no in_last -> overflow=1, word_count=8, done pulse, 9th in_valid not accepted (in_ready=0).
REQ-038 ADDRESS_WIDTH=3, 8 beats with in_last on 8th -> overflow=0, word_count=8.
REQ-039 rst_n low after 2 of 5 beats -> outputs zero at once; after release, rd addr 0,1 return written data; start again restarts at addr 0.
REQ-040 Write 0xAA then 0xBB to addr 0 across two loads with rd_en on addr 0 in the 0xBB write cycle -> rd_data=0xAA, next read 0xBB.
